dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
MEM-stage data-memory access controller for the pipelined MIPS core. It takes one load/store per instruction from the MEM stage and checks alignment. It builds byte enables and lane-replicated write data, then runs a req/ack handshake to a variable-latency word-wide data RAM, stalling the pipeline until the RAM acknowledges. On loads it delivers the raw RAM word, the latched low address bits and the load type to the downstream load-data extender.

Parameters:
AW, 32, byte-address width of addr_i / ram_addr_o.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
mem_req_i  in  1  MEM stage holds a valid load/store
mem_we_i  in  1  1 = store, 0 = load
store_type_i  in  2  00 sb, 01 sh, 10 sw, 11 illegal
load_type_i  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, others illegal
addr_i  in  AW  byte address
wdata_i  in  32  store data (rt)
stall_o  out  1  freeze PC/IF/ID/EX/MEM
done_o  out  1  access completed this cycle
rdata_o  out  32  raw RAM word of last completed load
ld_type_o  out  3  load type of last completed load
ld_addr_o  out  2  addr_i[1:0] of last completed load
adel_o  out  1  load address error pulse
ades_o  out  1  store address error pulse
ram_req_o  out  1  RAM request
ram_we_o  out  1  RAM write
ram_be_o  out  4  RAM byte enables
ram_addr_o  out  AW  word-aligned address, low 2 bits forced 0
ram_wdata_o  out  32  RAM write data
ram_ack_i  in  1  RAM ack; qualifies ram_rdata_i on loads
ram_rdata_i  in  32  RAM read word

Behaviour:
- Reset (reset=0, async): state IDLE. All registered outputs are 0: ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, rdata_o, ld_type_o, ld_addr_o, done_o, adel_o, ades_o. stall_o=0.
- FSM states: IDLE, REQ, DONE.
- IDLE with mem_req_i=1, alignment checked combinationally:
  - misaligned if lh/lhu/sh with addr_i[0]=1.
  - misaligned if lw/sw with addr_i[1:0]!=00.
  - illegal if store_type_i=11, or load_type_i is 101..111.
- IDLE, misaligned or illegal:
  - no RAM access; next cycle adel_o (load) or ades_o (store) pulses 1 for one cycle.
  - done_o=1 same cycle; stall_o=0 throughout; stay IDLE.
- IDLE, legal: go to REQ. Register the request fields:
  - ram_req_o=1, ram_we_o=mem_we_i, ram_addr_o={addr_i[AW-1:2],2'b00}.
  - sb: ram_be_o=4'b0001<<addr_i[1:0], ram_wdata_o={4{wdata_i[7:0]}}.
  - sh: ram_be_o=addr_i[1]?1100:0011, ram_wdata_o={2{wdata_i[15:0]}}.
  - sw: ram_be_o=1111, ram_wdata_o=wdata_i.
  - load: ram_be_o=1111, ram_wdata_o=0; latch load_type_i and addr_i[1:0] internally.
- REQ: hold all ram_* outputs stable until ram_ack_i=1.
  - On ack: ram_req_o, ram_we_o and ram_be_o go to 0 next cycle; go to DONE.
  - On load ack: rdata_o<=ram_rdata_i, ld_type_o and ld_addr_o take the latched values.
  - Minimum handshake: ack in the first REQ cycle gives a 3-cycle access (accept, REQ, DONE).
- DONE: done_o=1 for exactly one cycle; stall_o=0; pipeline advances; go to IDLE. mem_req_i is ignored in DONE, because it is the instruction just serviced.
- stall_o (combinational):
  - 1 in IDLE when mem_req_i=1 and the access is legal.
  - 1 throughout REQ.
  - 0 in DONE and 0 otherwise.
- rdata_o, ld_type_o and ld_addr_o hold until the next completed load; stores never change them.
- ram_ack_i in IDLE or DONE is ignored. Acks never queue.
- Reset mid-access (REQ): ram_req_o drops asynchronously, FSM goes to IDLE, and the in-flight access is abandoned with no done_o.
- Back-to-back accesses: the next instruction can be accepted the cycle after DONE, so throughput is one access per 3+N cycles.

Test Plan:
- sw addr=0x0000_0010, wdata=0xDEADBEEF, ack after 2 REQ cycles -> ram_addr_o=0x10, be=1111, wdata=0xDEADBEEF held 2 cycles, stall_o=1 for 3 cycles, done_o pulses once.
- sb addr=0x...13, wdata=0x000000A5 -> ram_be_o=1000, ram_wdata_o=0xA5A5A5A5, ram_addr_o=0x10.
- sh addr=0x...12, wdata=0x00001234 -> ram_be_o=1100, ram_wdata_o=0x12341234.
- lh addr=0x...22, RAM returns 0x8001_7FFF -> rdata_o=0x80017FFF, ld_type_o=010, ld_addr_o=10; downstream extender yields 0xFFFF8001.
- lw addr=0x...21 -> no ram_req_o, adel_o pulse, stall_o=0; sh addr=0x...03 -> ades_o pulse; store_type_i=11 -> ades_o pulse.
- reset=0 asserted in REQ with ack never given -> ram_req_o=0 immediately, state IDLE, no done_o; a subsequent legal lw completes normally.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller.
// Checks load/store alignment, builds byte enables and lane-replicated write
// data, runs a req/ack handshake to a variable-latency word RAM, and returns
// the raw load word plus its type and low address bits to the load extender.
module dm_access_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [1:0]    store_type_i,
  input  logic [2:0]    load_type_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic          stall_o,
  output logic          done_o,
  output logic [31:0]   rdata_o,
  output logic [2:0]    ld_type_o,
  output logic [1:0]    ld_addr_o,
  output logic          adel_o,
  output logic          ades_o,
  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_be_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic          ram_ack_i,
  input  logic [31:0]   ram_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] f_store_be(input logic [1:0] st, input logic [1:0] a);
    case (st)
      2'b00:   f_store_be = 4'b0001 << a;
      2'b01:   f_store_be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   f_store_be = 4'b1111;
      default: f_store_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated onto every lane the access could hit.
  function automatic logic [31:0] f_store_wdata(input logic [1:0] st, input logic [31:0] d);
    case (st)
      2'b00:   f_store_wdata = {4{d[7:0]}};
      2'b01:   f_store_wdata = {2{d[15:0]}};
      2'b10:   f_store_wdata = d;
      default: f_store_wdata = 32'h0000_0000;
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  logic          w_bad;
  logic [2:0]    r_lt, w_lt_nxt;
  logic [1:0]    r_la, w_la_nxt;
  logic          w_req_nxt, w_we_nxt, w_done_nxt, w_adel_nxt, w_ades_nxt;
  logic [3:0]    w_be_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [31:0]   w_wdata_nxt, w_rdata_nxt;
  logic [2:0]    w_ld_type_nxt;
  logic [1:0]    w_ld_addr_nxt;

  // Misaligned or illegal-encoding detection for the access presented in IDLE.
  always_comb begin
    w_bad = 1'b0;
    if (mem_we_i) begin
      case (store_type_i)
        2'b00:   w_bad = 1'b0;
        2'b01:   w_bad = addr_i[0];
        2'b10:   w_bad = |addr_i[1:0];
        default: w_bad = 1'b1;
      endcase
    end else begin
      case (load_type_i)
        3'b000, 3'b001: w_bad = 1'b0;
        3'b010, 3'b011: w_bad = addr_i[0];
        3'b100:         w_bad = |addr_i[1:0];
        default:        w_bad = 1'b1;
      endcase
    end
  end

  // Pipeline freeze: a legal request being accepted, or waiting for the RAM.
  assign stall_o = ((r_state == ST_IDLE) && mem_req_i && !w_bad) || (r_state == ST_REQ);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i && !w_bad) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ram_ack_i) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of every registered output.
  always_comb begin
    w_req_nxt     = ram_req_o;
    w_we_nxt      = ram_we_o;
    w_be_nxt      = ram_be_o;
    w_addr_nxt    = ram_addr_o;
    w_wdata_nxt   = ram_wdata_o;
    w_rdata_nxt   = rdata_o;
    w_ld_type_nxt = ld_type_o;
    w_ld_addr_nxt = ld_addr_o;
    w_lt_nxt      = r_lt;
    w_la_nxt      = r_la;
    w_done_nxt    = 1'b0;
    w_adel_nxt    = 1'b0;
    w_ades_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i && w_bad) begin
          // Faulting access completes at once with an address-error pulse.
          w_done_nxt = 1'b1;
          w_adel_nxt = ~mem_we_i;
          w_ades_nxt = mem_we_i;
        end else if (mem_req_i) begin
          w_req_nxt  = 1'b1;
          w_we_nxt   = mem_we_i;
          w_addr_nxt = {addr_i[AW-1:2], 2'b00};
          if (mem_we_i) begin
            w_be_nxt    = f_store_be(store_type_i, addr_i[1:0]);
            w_wdata_nxt = f_store_wdata(store_type_i, wdata_i);
          end else begin
            w_be_nxt    = 4'b1111;
            w_wdata_nxt = 32'h0000_0000;
            w_lt_nxt    = load_type_i;
            w_la_nxt    = addr_i[1:0];
          end
        end else begin
          w_req_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (ram_ack_i) begin
          w_req_nxt  = 1'b0;
          w_we_nxt   = 1'b0;
          w_be_nxt   = 4'b0000;
          w_done_nxt = 1'b1;
          if (!ram_we_o) begin
            w_rdata_nxt   = ram_rdata_i;
            w_ld_type_nxt = r_lt;
            w_ld_addr_nxt = r_la;
          end else begin
            w_rdata_nxt = rdata_o;
          end
        end else begin
          w_req_nxt = ram_req_o;
        end
      end
      ST_DONE: w_done_nxt = 1'b0;
      default: w_done_nxt = 1'b0;
    endcase
  end

  // Registered outputs and the latched load descriptor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_req_o   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_be_o    <= 4'b0000;
      ram_addr_o  <= {AW{1'b0}};
      ram_wdata_o <= 32'h0000_0000;
      rdata_o     <= 32'h0000_0000;
      ld_type_o   <= 3'b000;
      ld_addr_o   <= 2'b00;
      done_o      <= 1'b0;
      adel_o      <= 1'b0;
      ades_o      <= 1'b0;
      r_lt        <= 3'b000;
      r_la        <= 2'b00;
    end else begin
      ram_req_o   <= w_req_nxt;
      ram_we_o    <= w_we_nxt;
      ram_be_o    <= w_be_nxt;
      ram_addr_o  <= w_addr_nxt;
      ram_wdata_o <= w_wdata_nxt;
      rdata_o     <= w_rdata_nxt;
      ld_type_o   <= w_ld_type_nxt;
      ld_addr_o   <= w_ld_addr_nxt;
      done_o      <= w_done_nxt;
      adel_o      <= w_adel_nxt;
      ades_o      <= w_ades_nxt;
      r_lt        <= w_lt_nxt;
      r_la        <= w_la_nxt;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed testbench for dm_access_ctrl with hand-computed expectations.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  store_type_i = 2'b00;
  logic [2:0]  load_type_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        stall_o, done_o, adel_o, ades_o;
  logic [31:0] rdata_o;
  logic [2:0]  ld_type_o;
  logic [1:0]  ld_addr_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        ram_ack_i = 1'b0;
  logic [31:0] ram_rdata_i = 32'h0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.AW(32)) dut (
    .clk(clk), .reset(reset), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .store_type_i(store_type_i), .load_type_i(load_type_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .ld_type_o(ld_type_o), .ld_addr_o(ld_addr_o), .adel_o(adel_o), .ades_o(ades_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_ack_i(ram_ack_i),
    .ram_rdata_i(ram_rdata_i)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One legal access, ack given in REQ cycle n_req.
  task automatic run_access(input string nm, input logic we, input logic [1:0] st,
                            input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] wd,
                            input int n_req, input logic [31:0] rd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; store_type_i = st; load_type_i = lt;
    addr_i = addr; wdata_i = wd; ram_ack_i = 1'b0;
    #1 check_val({nm, "_accept_stall"}, stall_o, 1);
    for (int k = 0; k < n_req; k++) begin
      @(negedge clk);
      check_val({nm, "_req"}, ram_req_o, 1);
      check_val({nm, "_we"}, ram_we_o, we);
      check_val({nm, "_be"}, ram_be_o, exp_be);
      check_val({nm, "_addr"}, ram_addr_o, exp_addr);
      check_val({nm, "_wdata"}, ram_wdata_o, exp_wd);
      check_val({nm, "_req_done"}, done_o, 0);
      if (k == n_req - 1) begin
        ram_ack_i = 1'b1; ram_rdata_i = rd;
      end
      #1 check_val({nm, "_req_stall"}, stall_o, 1);
    end
    @(negedge clk);
    ram_ack_i = 1'b0; ram_rdata_i = 32'hFFFF_FFFF;
    check_val({nm, "_done"}, done_o, 1);
    check_val({nm, "_done_req"}, ram_req_o, 0);
    check_val({nm, "_done_we"}, ram_we_o, 0);
    check_val({nm, "_done_be"}, ram_be_o, 4'b0000);
    #1 check_val({nm, "_done_stall"}, stall_o, 0);
    mem_req_i = 1'b0;
    @(negedge clk);
    check_val({nm, "_done_once"}, done_o, 0);
    check_val({nm, "_idle_req"}, ram_req_o, 0);
  endtask

  // One faulting access: no RAM traffic, one error pulse with done.
  task automatic run_err(input string nm, input logic we, input logic [1:0] st,
                         input logic [2:0] lt, input logic [31:0] addr,
                         input logic exp_adel, input logic exp_ades);
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = we; store_type_i = st; load_type_i = lt; addr_i = addr;
    #1 check_val({nm, "_stall"}, stall_o, 0);
    @(negedge clk);
    check_val({nm, "_adel"}, adel_o, exp_adel);
    check_val({nm, "_ades"}, ades_o, exp_ades);
    check_val({nm, "_done"}, done_o, 1);
    check_val({nm, "_noreq"}, ram_req_o, 0);
    mem_req_i = 1'b0;
    #1 check_val({nm, "_stall2"}, stall_o, 0);
    @(negedge clk);
    check_val({nm, "_pulse_end"}, adel_o | ades_o | done_o, 0);
  endtask

  logic [31:0] ext_v;

  initial begin
    #12;
    check_val("rst_req", ram_req_o, 0);
    check_val("rst_we", ram_we_o, 0);
    check_val("rst_be", ram_be_o, 4'b0000);
    check_val("rst_addr", ram_addr_o, 0);
    check_val("rst_wdata", ram_wdata_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_ldinfo", {ld_type_o, ld_addr_o}, 5'b00000);
    check_val("rst_flags", {done_o, adel_o, ades_o, stall_o}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    run_access("sw", 1'b1, 2'b10, 3'b000, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0,
               32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    check_val("sw_rdata_kept", rdata_o, 0);

    run_access("lh", 1'b0, 2'b00, 3'b010, 32'h0000_0022, 32'h5555_5555, 1, 32'h8001_7FFF,
               32'h0000_0020, 4'b1111, 32'h0);
    check_val("lh_rdata", rdata_o, 32'h8001_7FFF);
    check_val("lh_type", ld_type_o, 3'b010);
    check_val("lh_laddr", ld_addr_o, 2'b10);
    ext_v = ld_addr_o[1] ? {{16{rdata_o[31]}}, rdata_o[31:16]} : {{16{rdata_o[15]}}, rdata_o[15:0]};
    check_val("lh_ext", ext_v, 32'hFFFF_8001);

    run_access("sb", 1'b1, 2'b00, 3'b000, 32'h0000_0013, 32'h0000_00A5, 3, 32'h0,
               32'h0000_0010, 4'b1000, 32'hA5A5_A5A5);
    check_val("sb_rdata_kept", rdata_o, 32'h8001_7FFF);
    check_val("sb_type_kept", ld_type_o, 3'b010);

    run_access("sh", 1'b1, 2'b01, 3'b000, 32'h0000_0012, 32'h0000_1234, 1, 32'h0,
               32'h0000_0010, 4'b1100, 32'h1234_1234);

    run_access("lbu", 1'b0, 2'b00, 3'b001, 32'h0000_0031, 32'h0, 2, 32'h0000_AB00,
               32'h0000_0030, 4'b1111, 32'h0);
    check_val("lbu_rdata", rdata_o, 32'h0000_AB00);
    check_val("lbu_info", {ld_type_o, ld_addr_o}, {3'b001, 2'b01});

    run_err("lw_mis", 1'b0, 2'b00, 3'b100, 32'h0000_0021, 1'b1, 1'b0);
    run_err("sh_mis", 1'b1, 2'b01, 3'b000, 32'h0000_0003, 1'b0, 1'b1);
    run_err("st_ill", 1'b1, 2'b11, 3'b000, 32'h0000_0000, 1'b0, 1'b1);
    run_err("ld_ill", 1'b0, 2'b00, 3'b101, 32'h0000_0000, 1'b1, 1'b0);
    check_val("err_rdata_kept", rdata_o, 32'h0000_AB00);

    // Stray ack while idle must not start or complete anything.
    @(negedge clk);
    ram_ack_i = 1'b1;
    @(negedge clk);
    ram_ack_i = 1'b0;
    check_val("idle_ack_done", done_o, 0);
    check_val("idle_ack_req", ram_req_o, 0);

    // Reset in REQ with no ack: abandon the access.
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b0; load_type_i = 3'b100; addr_i = 32'h0000_0040;
    @(negedge clk);
    check_val("mid_req", ram_req_o, 1);
    #2 reset = 1'b0;
    mem_req_i = 1'b0;
    #1;
    check_val("mid_req_drop", ram_req_o, 0);
    check_val("mid_stall", stall_o, 0);
    check_val("mid_done", done_o, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_after_done", done_o, 0);
    check_val("mid_after_req", ram_req_o, 0);

    run_access("lw", 1'b0, 2'b00, 3'b100, 32'h0000_0044, 32'h0, 1, 32'h1234_5678,
               32'h0000_0044, 4'b1111, 32'h0);
    check_val("lw_rdata", rdata_o, 32'h1234_5678);
    check_val("lw_info", {ld_type_o, ld_addr_o}, {3'b100, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
